// File: rtl/knight_rider_pkg.sv
// Shared encodings for the Knight Rider scanner blocks.
package knight_rider_pkg;

    typedef enum logic [1:0] {
        ST_SCAN_UP   = 2'd0,
        ST_DWELL_HI  = 2'd1,
        ST_SCAN_DOWN = 2'd2,
        ST_DWELL_LO  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int POS_W = 4;

endpackage

// File: rtl/knight_rider_scanner_tick_gen.sv
// Step strobe generator: one tick every DIV enabled clocks.
// The prescaler freezes while enable is low, so no step is lost or repeated.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] presc;

    assign tick = enable && (presc == LAST);

    // Count enabled cycles, wrapping to zero on the tick cycle.
    always_ff @(posedge clk) begin
        if (reset)
            presc <= '0;
        else if (tick)
            presc <= '0;
        else if (enable)
            presc <= presc + 1'b1;
    end

endmodule

// File: rtl/knight_rider_scanner.sv
// Bouncing LED scanner: walks pos 0 -> N_LEDS-1 -> 0 on step ticks,
// optionally dwelling at each end, and drives the decoded LED bar.
module knight_rider_scanner
    import knight_rider_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int DIV    = 4,
    parameter int DWELL  = 0,
    parameter int TRAIL  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [POS_W-1:0]  pos,
    output logic              dir,
    output logic              end_hit,
    output logic [N_LEDS-1:0] leds
);

    localparam logic [POS_W-1:0] TOP     = POS_W'(N_LEDS - 1);
    localparam logic [3:0]       DW_LAST = 4'(DWELL - 1);

    logic             tick;
    state_t           state, n_state;
    logic [3:0]       dwell_cnt, n_cnt;
    logic [POS_W-1:0] prev_pos, n_pos, n_prev;
    logic             n_dir, moved, n_end;
    logic [N_LEDS-1:0] n_leds;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    function automatic logic [N_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
        return N_LEDS'(1) << p;
    endfunction

    // Next-step decision; only a tick can move the scanner.
    always_comb begin
        n_state = state;
        n_cnt   = dwell_cnt;
        n_pos   = pos;
        n_dir   = dir;
        moved   = 1'b0;
        if (tick) begin
            case (state)
                ST_SCAN_UP: begin
                    if (pos < TOP) begin
                        n_pos = pos + 1'b1;
                        moved = 1'b1;
                    end else if (DWELL > 0) begin
                        n_state = ST_DWELL_HI;
                        n_cnt   = '0;
                    end else begin
                        n_dir   = DIR_DOWN;
                        n_pos   = pos - 1'b1;
                        moved   = 1'b1;
                        n_state = ST_SCAN_DOWN;
                    end
                end
                ST_DWELL_HI: begin
                    if (dwell_cnt == DW_LAST) begin
                        n_dir   = DIR_DOWN;
                        n_pos   = pos - 1'b1;
                        moved   = 1'b1;
                        n_state = ST_SCAN_DOWN;
                    end else begin
                        n_cnt = dwell_cnt + 1'b1;
                    end
                end
                ST_SCAN_DOWN: begin
                    if (pos > '0) begin
                        n_pos = pos - 1'b1;
                        moved = 1'b1;
                    end else if (DWELL > 0) begin
                        n_state = ST_DWELL_LO;
                        n_cnt   = '0;
                    end else begin
                        n_dir   = DIR_UP;
                        n_pos   = pos + 1'b1;
                        moved   = 1'b1;
                        n_state = ST_SCAN_UP;
                    end
                end
                default: begin  // ST_DWELL_LO
                    if (dwell_cnt == DW_LAST) begin
                        n_dir   = DIR_UP;
                        n_pos   = pos + 1'b1;
                        moved   = 1'b1;
                        n_state = ST_SCAN_UP;
                    end else begin
                        n_cnt = dwell_cnt + 1'b1;
                    end
                end
            endcase
        end
        n_prev = moved ? pos : prev_pos;
        n_end  = moved && ((n_pos == '0) || (n_pos == TOP));
        n_leds = onehot(n_pos) | ((TRAIL != 0) ? onehot(n_prev) : '0);
    end

    // Register FSM state and all outputs together so leds always track pos.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SCAN_UP;
            dwell_cnt <= '0;
            pos       <= '0;
            prev_pos  <= '0;
            dir       <= DIR_UP;
            end_hit   <= 1'b0;
            leds      <= N_LEDS'(1);
        end else begin
            state     <= n_state;
            dwell_cnt <= n_cnt;
            pos       <= n_pos;
            prev_pos  <= n_prev;
            dir       <= n_dir;
            end_hit   <= n_end;
            leds      <= n_leds;
        end
    end

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Four scanner configurations share clk/reset/enable and are checked each
// cycle against a tick-count model that derives position from the bounce
// period arithmetic.
module tb_knight_rider_scanner;

    logic clk = 1'b0;
    logic reset, enable;
    always #5 clk = ~clk;

    logic [3:0] pos0, pos1, pos2, pos3;
    logic       dir0, dir1, dir2, dir3;
    logic       eh0, eh1, eh2, eh3;
    logic [7:0] led0, led1, led2;
    logic [1:0] led3;

    knight_rider_scanner #(.N_LEDS(8), .DIV(4), .DWELL(0), .TRAIL(0)) u0 (
        .clk(clk), .reset(reset), .enable(enable),
        .pos(pos0), .dir(dir0), .end_hit(eh0), .leds(led0));
    knight_rider_scanner #(.N_LEDS(8), .DIV(1), .DWELL(2), .TRAIL(0)) u1 (
        .clk(clk), .reset(reset), .enable(enable),
        .pos(pos1), .dir(dir1), .end_hit(eh1), .leds(led1));
    knight_rider_scanner #(.N_LEDS(8), .DIV(1), .DWELL(0), .TRAIL(1)) u2 (
        .clk(clk), .reset(reset), .enable(enable),
        .pos(pos2), .dir(dir2), .end_hit(eh2), .leds(led2));
    knight_rider_scanner #(.N_LEDS(2), .DIV(1), .DWELL(0), .TRAIL(0)) u3 (
        .clk(clk), .reset(reset), .enable(enable),
        .pos(pos3), .dir(dir3), .end_hit(eh3), .leds(led3));

    int cfg_n  [4] = '{8, 8, 8, 2};
    int cfg_div[4] = '{4, 1, 1, 1};
    int cfg_dw [4] = '{0, 2, 0, 0};
    int cfg_tr [4] = '{0, 0, 1, 0};

    // model state: enabled-cycle count, tick count, position, previous, dir, end pulse
    int m_ecnt[4], m_k[4], m_pos[4], m_prev[4], m_dir[4], m_eh[4];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Position after k ticks: up ramp, top dwell, down ramp, bottom dwell.
    function automatic int pos_at(input int n, input int d, input int k);
        int p, t;
        p = 2 * (n - 1) + 2 * d;
        t = k % p;
        if (t <= n - 1 + d) return (t < n - 1) ? t : n - 1;
        if (t <= 2 * (n - 1) + d) return (n - 1) - (t - (n - 1 + d));
        return 0;
    endfunction

    task automatic model_edge(input logic r, input logic e);
        int np;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                m_ecnt[i] = 0; m_k[i] = 0; m_pos[i] = 0;
                m_prev[i] = 0; m_dir[i] = 0; m_eh[i] = 0;
            end else begin
                m_eh[i] = 0;
                if (e) begin
                    m_ecnt[i]++;
                    if (m_ecnt[i] % cfg_div[i] == 0) begin
                        m_k[i]++;
                        np = pos_at(cfg_n[i], cfg_dw[i], m_k[i]);
                        if (np != m_pos[i]) begin
                            m_dir[i]  = (np < m_pos[i]) ? 1 : 0;
                            m_prev[i] = m_pos[i];
                            m_pos[i]  = np;
                            m_eh[i]   = (np == 0 || np == cfg_n[i] - 1) ? 1 : 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0]  p[4];
        logic        d[4], h[4];
        logic [15:0] l[4], el;
        p = '{pos0, pos1, pos2, pos3};
        d = '{dir0, dir1, dir2, dir3};
        h = '{eh0, eh1, eh2, eh3};
        l = '{16'(led0), 16'(led1), 16'(led2), 16'(led3)};
        for (int i = 0; i < 4; i++) begin
            el = 16'(1) << m_pos[i];
            if (cfg_tr[i] != 0) el = el | (16'(1) << m_prev[i]);
            chk($sformatf("u%0d.pos", i),     16'(p[i]), 16'(m_pos[i]));
            chk($sformatf("u%0d.dir", i),     16'(d[i]), 16'(m_dir[i]));
            chk($sformatf("u%0d.end_hit", i), 16'(h[i]), 16'(m_eh[i]));
            chk($sformatf("u%0d.leds", i),    l[i],      el);
        end
    endtask

    task automatic cycle(input logic r, input logic e);
        reset  = r;
        enable = e;
        @(posedge clk);
        #1;
        model_edge(r, e);
        check_all();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        // reset overrides enable
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        // free run: several full periods of every configuration
        for (int c = 0; c < 150; c++) cycle(1'b0, 1'b1);
        // freeze windows of varying length
        for (int c = 0; c < 60; c++) cycle(1'b0, (c % 13) > 9 ? 1'b1 : (c % 5 != 0));
        // random enable with occasional reset, including mid-dwell/mid-scan
        for (int c = 0; c < 3000; c++)
            cycle(($urandom % 100) == 0, ($urandom % 10) < 7);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
